// File: rtl/summator.sv
// Bit-serial unsigned adder: captures two reglength-bit operands and adds them
// LSB first through one full adder and a carry flop, presenting a registered sum.
module summator #(
    parameter int unsigned reglength = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [reglength-1:0] r1,
    input  logic [reglength-1:0] r2,
    output logic [reglength:0]   sum,
    output logic                 done
);

    localparam int unsigned W     = reglength;
    localparam int unsigned CNT_W = (reglength > 1) ? $clog2(reglength) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     part_q, part_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [W:0]       sum_d;
    logic             done_d;

    logic             bit_c;
    logic             carry_c;
    logic [W-1:0]     part_shift_c;

    // Full adder on the current LSBs; new result bit enters from the MSB side.
    always_comb begin
        bit_c        = a_q[0] ^ b_q[0] ^ carry_q;
        carry_c      = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        part_shift_c = (part_q >> 1) | (W'(bit_c) << (W - 1));
    end

    // State and datapath registers; reset clears everything, including outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LOAD;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum     <= sum_d;
            done    <= done_d;
        end
    end

    // Next-state and next-register logic; every register holds unless updated.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum;
        done_d  = done;

        case (state_q)
            LOAD: begin
                a_d     = r1;
                b_d     = r2;
                carry_d = 1'b0;
                cnt_d   = '0;
                state_d = ADD;
            end

            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                part_d  = part_shift_c;
                carry_d = carry_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {carry_c, part_shift_c};
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_summator.sv
// Self-checking bench for summator: directed and random additions on widths 1, 3
// and 8, compared against plain r1 + r2 with a latency of reglength+1 edges.
module tb_summator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst3, rst8;
    logic [0:0] a1, b1;
    logic [1:0] s1;
    logic       d1;
    logic [2:0] a3, b3;
    logic [3:0] s3;
    logic       d3;
    logic [7:0] a8, b8;
    logic [8:0] s8;
    logic       d8;

    int tests = 0;
    int fails = 0;

    summator #(.reglength(1)) u_dut1 (.clk(clk), .reset(rst1), .r1(a1), .r2(b1), .sum(s1), .done(d1));
    summator #(.reglength(3)) u_dut3 (.clk(clk), .reset(rst3), .r1(a3), .r2(b3), .sum(s3), .done(d3));
    summator #(.reglength(8)) u_dut8 (.clk(clk), .reset(rst8), .r1(a8), .r2(b8), .sum(s8), .done(d8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b);
        case (w)
            1:       begin a1 = 1'(a); b1 = 1'(b); end
            3:       begin a3 = 3'(a); b3 = 3'(b); end
            default: begin a8 = 8'(a); b8 = 8'(b); end
        endcase
    endtask

    task automatic set_rst(input int w, input logic v);
        case (w)
            1:       rst1 = v;
            3:       rst3 = v;
            default: rst8 = v;
        endcase
    endtask

    function automatic logic [31:0] get_sum(input int w);
        case (w)
            1:       return 32'(s1);
            3:       return 32'(s3);
            default: return 32'(s8);
        endcase
    endfunction

    function automatic logic [31:0] get_done(input int w);
        case (w)
            1:       return 32'(d1);
            3:       return 32'(d3);
            default: return 32'(d8);
        endcase
    endfunction

    // mode 0: operands steady; 1: switch to (na, nb) after the load edge;
    // 2: fresh random operands after every edge.
    task automatic run_add(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                           input int mode, input logic [31:0] na, input logic [31:0] nb,
                           input int hold, input string tag);
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        mask     = (32'd1 << w) - 32'd1;
        a        = a_in & mask;
        b        = b_in & mask;
        expected = a + b;
        drive(w, a, b);
        set_rst(w, 1'b0);
        tick();
        check($sformatf("%s rst sum", tag), get_sum(w), 32'd0);
        set_rst(w, 1'b1);
        for (int e = 1; e <= w; e++) begin
            tick();
            check($sformatf("%s e%0d sum", tag, e), get_sum(w), 32'd0);
            check($sformatf("%s e%0d done", tag, e), get_done(w), 32'd0);
            if (mode == 1 && e == 1) drive(w, na, nb);
            if (mode == 2) drive(w, $urandom, $urandom);
        end
        tick();
        check($sformatf("%s %0d+%0d sum", tag, a, b), get_sum(w), expected);
        check($sformatf("%s done", tag), get_done(w), 32'd1);
        for (int h = 0; h < hold; h++) begin
            if (mode == 2) drive(w, $urandom, $urandom);
            tick();
            check($sformatf("%s hold%0d sum", tag, h), get_sum(w), expected);
            check($sformatf("%s hold%0d done", tag, h), get_done(w), 32'd1);
        end
    endtask

    initial begin
        rst1 = 1'b0; rst3 = 1'b0; rst8 = 1'b0;
        a1 = '0; b1 = '0; a3 = '0; b3 = '0; a8 = '0; b8 = '0;

        // Reset held low keeps all outputs at zero.
        for (int i = 0; i < 4; i++) begin
            drive(3, $urandom, $urandom);
            tick();
            check("held rst sum3", get_sum(3), 32'd0);
            check("held rst done3", get_done(3), 32'd0);
            check("held rst sum8", get_sum(8), 32'd0);
        end

        run_add(3, 3, 5, 0, 0, 0, 6, "basic");
        run_add(3, 7, 7, 0, 0, 0, 1, "max");
        run_add(3, 0, 0, 0, 0, 0, 1, "zero");
        run_add(3, 2, 1, 1, 7, 7, 2, "opchg");

        // Reset from DONE clears outputs on that edge.
        set_rst(3, 1'b0);
        tick();
        check("rst from done sum", get_sum(3), 32'd0);
        check("rst from done done", get_done(3), 32'd0);

        // Reset in the middle of an addition discards the partial work.
        drive(3, 7, 7);
        set_rst(3, 1'b1);
        tick();
        tick();
        set_rst(3, 1'b0);
        tick();
        check("midop sum", get_sum(3), 32'd0);
        check("midop done", get_done(3), 32'd0);
        set_rst(3, 1'b1);
        tick();
        tick();
        tick();
        check("midop restart early sum", get_sum(3), 32'd0);
        tick();
        check("midop restart sum", get_sum(3), 32'd14);
        run_add(3, 6, 4, 0, 0, 0, 0, "after midop");

        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                run_add(3, 32'(x), 32'(y), 0, 0, 0, 0, "exh");

        for (int t = 0; t < 8; t++) begin
            run_add(1, $urandom, $urandom, 2, 0, 0, 1, "rnd w1");
            run_add(8, $urandom, $urandom, 2, 0, 0, 1, "rnd w8");
            run_add(3, $urandom, $urandom, 2, 0, 0, 1, "rnd w3");
        end
        run_add(8, 255, 255, 0, 0, 0, 1, "max w8");
        run_add(1, 1, 1, 0, 0, 0, 1, "max w1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
